// File: rtl/mat_pkg.sv
// Shared constants and FSM encoding for the matrix add/sub scheduler.
package mat_pkg;

  // Elements per 3x3 operand matrix.
  localparam int MAT_SIZE = 9;
  // Reads per job: 9 A elements followed by 9 B elements.
  localparam int LOAD_LEN = 18;
  // Width of the requester read address (0..17).
  localparam int SRC_AW   = 5;
  // Width of engine element addresses and result indices (0..8).
  localparam int IDX_W    = 4;

  // Scheduler FSM states. The encoding is exported on dbg_state.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    START   = 3'd2,
    RUN     = 3'd3,
    RELEASE = 3'd4
  } state_t;

endpackage

// File: rtl/matrix_addsub_sched_rr_arbiter.sv
// Combinational round-robin arbiter: picks the first set request at or
// after the pointer, wrapping. The pointer register lives in the caller.
module rr_arbiter #(
  parameter int NREQ = 4,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic            any
);

  // Scan NREQ positions starting at ptr; the first hit wins.
  always_comb begin
    logic          found;
    logic [PW-1:0] idx;
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int i = 0; i < NREQ; i++) begin
      idx = PW'((int'(ptr) + i) % NREQ);
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

  assign any = |req;

endmodule

// File: rtl/matrix_addsub_sched.sv
// Round-robin scheduler sharing one 3x3 add/sub engine among NREQ
// requesters. A job: grant, pull 18 operand elements from the requester,
// write them into the engine, start it, route its 9 results back, release.
//
// Handshakes (all strobes are single-cycle, no backpressure anywhere):
//   src_rd/src_addr -> requester returns src_data exactly one cycle later.
//   eng_*_wen writes take effect on the clock edge they are high.
//   eng_c_valid is accepted only in RUN; each accepted result is forwarded
//   on res_valid/res_data/res_idx one cycle later.
//   job_done (and job_err) pulse for one cycle in RELEASE.
module matrix_addsub_sched
  import mat_pkg::*;
#(
  parameter int NREQ       = 4,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req,
  input  logic [NREQ-1:0]            req_op,
  output logic [NREQ-1:0]            gnt,
  output logic                       src_rd,
  output logic [SRC_AW-1:0]          src_addr,
  input  logic [NREQ*DATA_WIDTH-1:0] src_data,
  output logic                       eng_start,
  output logic                       eng_op,
  output logic [DATA_WIDTH-1:0]      eng_a_in,
  output logic [DATA_WIDTH-1:0]      eng_b_in,
  output logic [IDX_W-1:0]           eng_a_addr,
  output logic [IDX_W-1:0]           eng_b_addr,
  output logic                       eng_a_wen,
  output logic                       eng_b_wen,
  input  logic [DATA_WIDTH-1:0]      eng_c_out,
  input  logic                       eng_c_valid,
  input  logic                       eng_done,
  output logic [NREQ-1:0]            res_valid,
  output logic [DATA_WIDTH-1:0]      res_data,
  output logic [IDX_W-1:0]           res_idx,
  output logic [NREQ-1:0]            job_done,
  output logic                       job_err,
  output logic                       busy,
  output logic [2:0]                 dbg_state
);

  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WDW = $clog2(TIMEOUT) + 1;
  localparam logic [WDW-1:0]    WD_LAST   = WDW'(TIMEOUT - 1);
  localparam logic [WDW-1:0]    WD_MAX    = '1;
  localparam logic [SRC_AW-1:0] LOAD_LAST = SRC_AW'(LOAD_LEN - 1);
  localparam logic [SRC_AW-1:0] B_BASE    = SRC_AW'(MAT_SIZE);
  localparam logic [IDX_W-1:0]  RES_FULL  = IDX_W'(MAT_SIZE);
  localparam logic [IDX_W-1:0]  RES_MAX   = '1;
  localparam logic [PW-1:0]     PTR_LAST  = PW'(NREQ - 1);

  state_t                  state;
  state_t                  state_nxt;
  logic [NREQ-1:0]         arb_grant;
  logic                    arb_any;
  logic [PW-1:0]           ptr;
  logic [PW-1:0]           gnt_idx;
  logic [SRC_AW-1:0]       load_cnt;
  logic [IDX_W-1:0]        res_cnt;
  logic [WDW-1:0]          wdog;
  logic                    wd_hit;
  logic                    wd_fired;
  logic                    wr_pend;
  logic [SRC_AW-1:0]       wr_addr;
  logic [DATA_WIDTH-1:0]   src_sel;
  logic                    res_fire;

  rr_arbiter #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req   (req),
    .ptr   (ptr),
    .grant (arb_grant),
    .any   (arb_any)
  );

  assign wd_hit    = (wdog == WD_LAST);
  assign res_fire  = (state == RUN) && eng_c_valid;
  assign dbg_state = state;

  // Index of the granted requester, used to advance the pointer.
  always_comb begin
    gnt_idx = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) gnt_idx = PW'(i);
    end
  end

  // Read-data mux: gnt is one-hot, so an AND-OR select is enough.
  always_comb begin
    src_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      src_sel = src_sel | (src_data[i*DATA_WIDTH +: DATA_WIDTH] & {DATA_WIDTH{gnt[i]}});
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // FSM next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (arb_any) state_nxt = LOAD;
      LOAD:    if (load_cnt == LOAD_LAST) state_nxt = START;
      START:   state_nxt = RUN;
      RUN:     if (eng_done || wd_hit) state_nxt = RELEASE;
      RELEASE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State-decoded outputs: requester reads, engine start, completion.
  always_comb begin
    src_rd    = 1'b0;
    src_addr  = '0;
    eng_start = 1'b0;
    job_done  = '0;
    job_err   = 1'b0;
    busy      = (state != IDLE);
    case (state)
      LOAD: begin
        src_rd   = 1'b1;
        src_addr = load_cnt;
      end
      START: eng_start = 1'b1;
      RELEASE: begin
        job_done = gnt;
        job_err  = wd_fired || (res_cnt != RES_FULL);
      end
      default: ;
    endcase
  end

  // Engine write port: the read issued last cycle lands now. The last
  // write overlaps the START cycle.
  always_comb begin
    eng_a_wen  = wr_pend && (wr_addr < B_BASE);
    eng_b_wen  = wr_pend && (wr_addr >= B_BASE);
    eng_a_in   = eng_a_wen ? src_sel : '0;
    eng_b_in   = eng_b_wen ? src_sel : '0;
    eng_a_addr = eng_a_wen ? IDX_W'(wr_addr) : '0;
    eng_b_addr = eng_b_wen ? IDX_W'(wr_addr - B_BASE) : '0;
  end

  // Job bookkeeping: grant/op capture, counters, watchdog, pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt      <= '0;
      eng_op   <= 1'b0;
      ptr      <= '0;
      load_cnt <= '0;
      res_cnt  <= '0;
      wdog     <= '0;
      wd_fired <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (arb_any) begin
            gnt      <= arb_grant;
            eng_op   <= |(req_op & arb_grant);
            load_cnt <= '0;
          end
        end
        LOAD: load_cnt <= load_cnt + SRC_AW'(1);
        START: begin
          res_cnt  <= '0;
          wdog     <= '0;
          wd_fired <= 1'b0;
        end
        RUN: begin
          if (wdog != WD_MAX) wdog <= wdog + WDW'(1);
          // Saturate so an over-long result burst still reads as a bad count.
          if (eng_c_valid && (res_cnt != RES_MAX)) res_cnt <= res_cnt + IDX_W'(1);
          if (wd_hit && !eng_done) wd_fired <= 1'b1;
        end
        RELEASE: begin
          gnt <= '0;
          ptr <= (gnt_idx == PTR_LAST) ? '0 : gnt_idx + PW'(1);
        end
        default: ;
      endcase
    end
  end

  // One-stage write pipeline tracking the read issued in LOAD.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_pend <= 1'b0;
      wr_addr <= '0;
    end else begin
      wr_pend <= (state == LOAD);
      wr_addr <= load_cnt;
    end
  end

  // One-stage result pipeline back to the granted requester.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid <= '0;
      res_data  <= '0;
      res_idx   <= '0;
    end else begin
      res_valid <= res_fire ? gnt : '0;
      if (res_fire) begin
        res_data <= eng_c_out;
        res_idx  <= res_cnt;
      end
    end
  end

endmodule

// File: tb/tb_matrix_addsub_sched.sv
// Self-checking bench for matrix_addsub_sched with a behavioural engine
// stub, requester memories and a result scoreboard.
module tb_matrix_addsub_sched;
  import mat_pkg::*;

  localparam int NREQ    = 4;
  localparam int DW      = 32;
  localparam int TIMEOUT = 64;
  localparam int SBW     = 3 + IDX_W + DW;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NREQ-1:0]      req;
  logic [NREQ-1:0]      req_op;
  logic [NREQ-1:0]      gnt;
  logic                 src_rd;
  logic [SRC_AW-1:0]    src_addr;
  logic [NREQ*DW-1:0]   src_data;
  logic                 eng_start;
  logic                 eng_op;
  logic [DW-1:0]        eng_a_in;
  logic [DW-1:0]        eng_b_in;
  logic [IDX_W-1:0]     eng_a_addr;
  logic [IDX_W-1:0]     eng_b_addr;
  logic                 eng_a_wen;
  logic                 eng_b_wen;
  logic [DW-1:0]        eng_c_out;
  logic                 eng_c_valid;
  logic                 eng_done;
  logic [NREQ-1:0]      res_valid;
  logic [DW-1:0]        res_data;
  logic [IDX_W-1:0]     res_idx;
  logic [NREQ-1:0]      job_done;
  logic                 job_err;
  logic                 busy;
  logic [2:0]           dbg_state;

  int checks = 0;
  int errors = 0;
  logic [SBW-1:0] exp_q[$];
  logic [DW-1:0]  a_data[NREQ][MAT_SIZE];
  logic [DW-1:0]  b_data[NREQ][MAT_SIZE];
  logic [DW-1:0]  a_mem[MAT_SIZE];
  logic [DW-1:0]  b_mem[MAT_SIZE];
  logic [SRC_AW-1:0] addr_q = '0;
  bit   eng_hang = 1'b0;
  logic eng_op_l;
  int   rd_count = 0;
  int   rd_last  = 0;

  matrix_addsub_sched #(.NREQ(NREQ), .DATA_WIDTH(DW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .req(req), .req_op(req_op), .gnt(gnt),
    .src_rd(src_rd), .src_addr(src_addr), .src_data(src_data),
    .eng_start(eng_start), .eng_op(eng_op),
    .eng_a_in(eng_a_in), .eng_b_in(eng_b_in),
    .eng_a_addr(eng_a_addr), .eng_b_addr(eng_b_addr),
    .eng_a_wen(eng_a_wen), .eng_b_wen(eng_b_wen),
    .eng_c_out(eng_c_out), .eng_c_valid(eng_c_valid), .eng_done(eng_done),
    .res_valid(res_valid), .res_data(res_data), .res_idx(res_idx),
    .job_done(job_done), .job_err(job_err), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1, "global timeout");
  end

  // ---------------- requester and engine models ----------------
  // Requesters answer one cycle after each read.
  always @(posedge clk) addr_q <= src_addr;

  always @* begin
    for (int i = 0; i < NREQ; i++) begin
      if (addr_q < 5'd9) src_data[i*DW +: DW] = a_data[i][addr_q[3:0]];
      else               src_data[i*DW +: DW] = b_data[i][4'(addr_q - 5'd9)];
    end
  end

  // Engine operand memories.
  always @(posedge clk) begin
    if (eng_a_wen) a_mem[eng_a_addr] <= eng_a_in;
    if (eng_b_wen) b_mem[eng_b_addr] <= eng_b_in;
  end

  // Engine stub: one idle cycle after start, 9 results, then done
  // (done suppressed when eng_hang is set).
  initial begin
    eng_c_valid = 1'b0;
    eng_c_out   = '0;
    eng_done    = 1'b0;
    forever begin
      @(negedge clk);
      if (eng_start === 1'b1) begin
        eng_op_l = eng_op;
        @(negedge clk);
        for (int k = 0; k < MAT_SIZE; k++) begin
          eng_c_valid = 1'b1;
          eng_c_out   = eng_op_l ? a_mem[k] - b_mem[k] : a_mem[k] + b_mem[k];
          @(negedge clk);
        end
        eng_c_valid = 1'b0;
        eng_c_out   = '0;
        if (!eng_hang) begin
          eng_done = 1'b1;
          @(negedge clk);
          eng_done = 1'b0;
        end
      end
    end
  end

  function automatic logic [2:0] idx_of(input logic [NREQ-1:0] v);
    idx_of = 3'd7;
    for (int i = 0; i < NREQ; i++) begin
      if (v == (NREQ'(1) << i)) idx_of = 3'(i);
    end
  endfunction

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    logic [SBW-1:0] exp_e;
    logic [SBW-1:0] obs_e;
    if (rst) begin
      rd_count = 0;
    end else begin
      if (src_rd === 1'b1) begin
        checks++;
        if (src_addr !== SRC_AW'(rd_count)) begin
          errors++;
          $display("FAIL src_addr: got %0d want %0d", src_addr, rd_count);
        end
        rd_count++;
      end
      if (res_valid !== '0) begin
        checks++;
        obs_e = {idx_of(res_valid), res_idx, res_data};
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL result_unexpected: got req=%0d idx=%0d data=%h, want none", obs_e[SBW-1 -: 3], res_idx, res_data);
        end else begin
          exp_e = exp_q.pop_front();
          if (obs_e !== exp_e) begin
            errors++;
            $display("FAIL result: got req=%0d idx=%0d data=%h, want req=%0d idx=%0d data=%h",
                     obs_e[SBW-1 -: 3], obs_e[DW +: IDX_W], obs_e[DW-1:0],
                     exp_e[SBW-1 -: 3], exp_e[DW +: IDX_W], exp_e[DW-1:0]);
          end
        end
      end
      if (job_done !== '0) begin
        rd_last  = rd_count;
        rd_count = 0;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_job(input int id, input bit op);
    for (int k = 0; k < MAT_SIZE; k++) begin
      exp_q.push_back({3'(id), IDX_W'(k), op ? a_data[id][k] - b_data[id][k] : a_data[id][k] + b_data[id][k]});
    end
  endtask

  task automatic fill_random(input int id);
    for (int k = 0; k < MAT_SIZE; k++) begin
      a_data[id][k] = $urandom_range(32'hFFFF_FFFF, 0);
      b_data[id][k] = $urandom_range(32'hFFFF_FFFF, 0);
    end
  endtask

  task automatic apply_reset;
    rst    = 1'b1;
    req    = '0;
    req_op = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_done(output int id, output logic err, output logic [NREQ-1:0] jd,
                           output logic [NREQ-1:0] g, output int cyc, input int budget);
    bit seen = 1'b0;
    id = -1; err = 1'b0; jd = '0; g = '0; cyc = 0;
    while (!seen && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (job_done !== '0) begin
        seen = 1'b1;
        jd   = job_done;
        id   = int'(idx_of(job_done));
        err  = job_err;
        g    = gnt;
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL job_done_wait: got no job_done in %0d cycles, want one", budget);
    end
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget);
    int n = 0;
    while (dbg_state !== s && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (dbg_state !== s) begin
      errors++;
      $display("FAIL state_wait: got state %0d want %0d", dbg_state, s);
    end
  endtask

  // Post-job checks one cycle after job_done.
  task automatic check_post(input string name, input int want_rd);
    @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_results_left: got %0d pending, want 0", name, exp_q.size());
    end
    checks++;
    if (rd_last != want_rd) begin
      errors++;
      $display("FAIL %s_reads: got %0d want %0d", name, rd_last, want_rd);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    rst = 1'b1; req = '0; req_op = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({gnt, src_rd, eng_start, job_done, job_err, res_valid, busy} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got gnt=%b rd=%b start=%b done=%b err=%b rv=%b busy=%b, want all 0",
               gnt, src_rd, eng_start, job_done, job_err, res_valid, busy);
    end
    checks++;
    if ({eng_a_wen, eng_b_wen, eng_op, src_addr, res_idx} !== '0) begin
      errors++;
      $display("FAIL reset_engine_if: got awen=%b bwen=%b op=%b addr=%0d idx=%0d, want 0",
               eng_a_wen, eng_b_wen, eng_op, src_addr, res_idx);
    end
    checks++;
    if (dbg_state !== 3'(IDLE)) begin
      errors++;
      $display("FAIL reset_state: got %0d want %0d", dbg_state, IDLE);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single;
    int id, cyc; logic err; logic [NREQ-1:0] jd, g;
    for (int k = 0; k < MAT_SIZE; k++) begin
      a_data[1][k] = DW'(k + 1);
      b_data[1][k] = DW'(k + 10);
    end
    push_job(1, 1'b0);
    req_op = 4'b0000;
    req    = 4'b0010;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0010) begin
      errors++;
      $display("FAIL single_gnt: got %b want 0010", gnt);
    end
    wait_done(id, err, jd, g, cyc, 200);
    req = '0;
    checks++;
    if (id != 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL single_done: got id=%0d err=%b, want id=1 err=0", id, err);
    end
    check_post("single", LOAD_LEN);
  endtask

  task automatic test_round_robin;
    int id, cyc; logic err; logic [NREQ-1:0] jd, g;
    apply_reset();
    for (int i = 0; i < NREQ; i++) fill_random(i);
    push_job(0, 1'b0); push_job(1, 1'b1); push_job(2, 1'b0); push_job(3, 1'b1); push_job(0, 1'b0);
    req_op = 4'b1010;
    req    = 4'b1111;
    for (int j = 0; j < 5; j++) begin
      wait_done(id, err, jd, g, cyc, 200);
      if (id >= 0 && id < NREQ && j != 0) req[id] = 1'b0;
      checks++;
      if (id != j % NREQ || err !== 1'b0) begin
        errors++;
        $display("FAIL rr_order: job %0d got id=%0d err=%b, want id=%0d err=0", j, id, err, j % NREQ);
      end
      checks++;
      if (g !== jd || !$onehot(g)) begin
        errors++;
        $display("FAIL rr_gnt: job %0d got gnt=%b done=%b, want equal one-hot", j, g, jd);
      end
    end
    req = '0;
    check_post("rr", LOAD_LEN);
  endtask

  task automatic test_sub_boundary;
    int id, cyc; logic err; logic [NREQ-1:0] jd, g;
    fill_random(2);
    a_data[2][0] = 32'h8000_0000;
    b_data[2][0] = 32'h0000_0001;
    push_job(2, 1'b1);
    req_op = 4'b0100;
    req    = 4'b0100;
    wait_done(id, err, jd, g, cyc, 200);
    req = '0;
    checks++;
    if (id != 2 || err !== 1'b0) begin
      errors++;
      $display("FAIL sub_done: got id=%0d err=%b, want id=2 err=0", id, err);
    end
    check_post("sub", LOAD_LEN);
  endtask

  task automatic test_timeout;
    int id, cyc; logic err; logic [NREQ-1:0] jd, g;
    eng_hang = 1'b1;
    fill_random(3);
    push_job(3, 1'b0);
    req_op = 4'b0000;
    req    = 4'b1000;
    wait_state(3'(START), 50);
    wait_done(id, err, jd, g, cyc, 300);
    req = '0;
    eng_hang = 1'b0;
    checks++;
    if (id != 3 || err !== 1'b1) begin
      errors++;
      $display("FAIL timeout_done: got id=%0d err=%b, want id=3 err=1", id, err);
    end
    checks++;
    if (cyc != TIMEOUT + 1) begin
      errors++;
      $display("FAIL timeout_latency: got %0d cycles after START, want %0d", cyc, TIMEOUT + 1);
    end
    check_post("timeout", LOAD_LEN);
    fill_random(0);
    push_job(0, 1'b1);
    req_op = 4'b0001;
    req    = 4'b0001;
    wait_done(id, err, jd, g, cyc, 200);
    req = '0;
    checks++;
    if (id != 0 || err !== 1'b0) begin
      errors++;
      $display("FAIL after_timeout_done: got id=%0d err=%b, want id=0 err=0", id, err);
    end
    check_post("after_timeout", LOAD_LEN);
  endtask

  task automatic test_reset_mid_load;
    int id, cyc; logic err; logic [NREQ-1:0] jd, g;
    bit saw_done = 1'b0;
    fill_random(2);
    req_op = 4'b0000;
    req    = 4'b0100;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL midrst_gnt: got %b want 0100", gnt);
    end
    repeat (6) @(negedge clk);
    checks++;
    if (src_addr !== 5'd6 || src_rd !== 1'b1) begin
      errors++;
      $display("FAIL midrst_load_pos: got rd=%b addr=%0d want rd=1 addr=6", src_rd, src_addr);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if ({gnt, src_rd, busy, eng_a_wen, eng_b_wen, job_done, dbg_state} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs: got gnt=%b rd=%b busy=%b awen=%b bwen=%b done=%b st=%0d, want 0",
               gnt, src_rd, busy, eng_a_wen, eng_b_wen, job_done, dbg_state);
    end
    req = '0;
    repeat (2) begin
      @(negedge clk);
      if (job_done !== '0) saw_done = 1'b1;
    end
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (job_done !== '0) saw_done = 1'b1;
    end
    checks++;
    if (saw_done) begin
      errors++;
      $display("FAIL midrst_no_done: got a job_done after reset, want none");
    end
    fill_random(0);
    fill_random(3);
    push_job(0, 1'b0);
    push_job(3, 1'b1);
    req_op = 4'b1000;
    req    = 4'b1001;
    @(negedge clk);
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL midrst_ptr: got gnt=%b want 0001", gnt);
    end
    wait_done(id, err, jd, g, cyc, 200);
    req[0] = 1'b0;
    checks++;
    if (id != 0 || err !== 1'b0) begin
      errors++;
      $display("FAIL midrst_job0: got id=%0d err=%b, want id=0 err=0", id, err);
    end
    wait_done(id, err, jd, g, cyc, 200);
    req[3] = 1'b0;
    checks++;
    if (id != 3 || err !== 1'b0) begin
      errors++;
      $display("FAIL midrst_job3: got id=%0d err=%b, want id=3 err=0", id, err);
    end
    check_post("midrst", LOAD_LEN);
  endtask

  task automatic test_drop_req;
    int id, cyc; logic err; logic [NREQ-1:0] jd, g;
    fill_random(1);
    push_job(1, 1'b1);
    req_op = 4'b0010;
    req    = 4'b0010;
    wait_state(3'(RUN), 50);
    req = '0;
    wait_done(id, err, jd, g, cyc, 200);
    checks++;
    if (id != 1 || err !== 1'b0) begin
      errors++;
      $display("FAIL drop_done: got id=%0d err=%b, want id=1 err=0", id, err);
    end
    check_post("drop", LOAD_LEN);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst = 1'b1; req = '0; req_op = '0;
    for (int i = 0; i < NREQ; i++) fill_random(i);
    test_reset();
    test_single();
    test_round_robin();
    test_sub_boundary();
    test_timeout();
    test_reset_mid_load();
    test_drop_req();
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
